// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, FIFO sizing defaults and the state encodings
// used by the transmit feeder and the transmitter.
package uart_pkg;

  localparam int unsigned UART_BYTE_W      = 8;
  localparam int unsigned UART_FIFO_DEPTH  = 16;
  localparam int unsigned UART_FIFO_ADDR_W = 4;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StWaitDone = 2'b01,
    StWaitClr  = 2'b10
  } feed_state_e;

  typedef enum logic [2:0] {
    TxStIdle    = 3'b000,
    TxStStart   = 3'b001,
    TxStData    = 3'b010,
    TxStStop    = 3'b011,
    TxStCleanup = 3'b100
  } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with registered full/empty/count and a one-cycle overflow pulse.
// No fall-through: a byte written into an empty FIFO is poppable on the following cycle.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned p_DEPTH  = UART_FIFO_DEPTH,
  parameter int unsigned p_ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Wr_En,
  input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
  input  logic                   i_Pop,
  output logic [UART_BYTE_W-1:0] o_Rd_Byte,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [p_ADDR_W:0]      o_Count,
  output logic                   o_Overflow
);

  localparam logic [p_ADDR_W:0] DepthCount = (p_ADDR_W + 1)'(p_DEPTH);

  logic [UART_BYTE_W-1:0] mem_q [p_DEPTH];
  logic [p_ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [p_ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [p_ADDR_W:0]      count_q, count_d;
  logic                   full_q, empty_q, overflow_q;
  logic                   do_wr, do_pop;

  always_comb begin
    do_pop   = i_Pop & ~empty_q;
    // A pop frees a slot on the same edge, so a full FIFO still takes the write.
    do_wr    = i_Wr_En & (~full_q | do_pop);
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_wr, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == DepthCount);
      empty_q    <= (count_d == '0);
      overflow_q <= i_Wr_En & ~do_wr;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge i_Clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= i_Wr_Byte;
    end
  end

  assign o_Rd_Byte  = mem_q[rd_ptr_q];
  assign o_Full     = full_q;
  assign o_Empty    = empty_q;
  assign o_Count    = count_q;
  assign o_Overflow = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers system bytes and feeds them to the UART transmitter one frame at a time,
// holding each byte stable for the whole frame and pulsing Ready once per frame.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned p_DEPTH  = UART_FIFO_DEPTH,
  parameter int unsigned p_ADDR_W = UART_FIFO_ADDR_W
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
  input  logic                   i_Wr_En,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [p_ADDR_W:0]      o_Count,
  output logic                   o_Overflow,
  output logic [UART_BYTE_W-1:0] o_Tx_Byte,
  output logic                   o_Tx_Ready,
  input  logic                   i_Tx_Completed
);

  feed_state_e            state_q, state_d;
  logic                   pop;
  logic                   fifo_empty;
  logic [UART_BYTE_W-1:0] fifo_byte;
  logic [UART_BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic                   tx_ready_q, tx_ready_d;

  uart_byte_fifo #(
    .p_DEPTH  (p_DEPTH),
    .p_ADDR_W (p_ADDR_W)
  ) u_fifo (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Wr_En    (i_Wr_En),
    .i_Wr_Byte  (i_Wr_Byte),
    .i_Pop      (pop),
    .o_Rd_Byte  (fifo_byte),
    .o_Full     (o_Full),
    .o_Empty    (fifo_empty),
    .o_Count    (o_Count),
    .o_Overflow (o_Overflow)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= StIdle;
      tx_byte_q  <= '0;
      tx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_byte_q  <= tx_byte_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // WAIT_CLR keeps a Completed level left over from the last frame from being
  // mistaken for the end of the next one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (!fifo_empty)     state_d = StWaitDone;
      StWaitDone: if (i_Tx_Completed)  state_d = StWaitClr;
      StWaitClr:  if (!i_Tx_Completed) state_d = StIdle;
      default:                         state_d = StIdle;
    endcase
  end

  always_comb begin
    pop        = (state_q == StIdle) & ~fifo_empty;
    tx_ready_d = pop;
    tx_byte_d  = pop ? fifo_byte : tx_byte_q;
  end

  assign o_Empty    = fifo_empty;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Tx_Ready = tx_ready_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Feeder paired with a behavioural transmitter (4 clocks per bit), a serial-line decoder
// and a queue-based reference model checked on every clock.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int          CLKS   = 4;

  logic              i_Clk = 1'b0;
  logic              i_Rst;
  logic [7:0]        i_Wr_Byte;
  logic              i_Wr_En;
  logic              o_Full, o_Empty, o_Overflow, o_Tx_Ready;
  logic [ADDR_W:0]   o_Count;
  logic [7:0]        o_Tx_Byte;

  logic tx_serial    = 1'b1;
  logic tx_completed = 1'b0;
  logic tx_sending   = 1'b0;
  int   tx_tick      = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_feeder #(
    .p_DEPTH  (DEPTH),
    .p_ADDR_W (ADDR_W)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rst          (i_Rst),
    .i_Wr_Byte      (i_Wr_Byte),
    .i_Wr_En        (i_Wr_En),
    .o_Full         (o_Full),
    .o_Empty        (o_Empty),
    .o_Count        (o_Count),
    .o_Overflow     (o_Overflow),
    .o_Tx_Byte      (o_Tx_Byte),
    .o_Tx_Ready     (o_Tx_Ready),
    .i_Tx_Completed (tx_completed)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transmitter: samples Ready only when idle, reads the byte live, raises Completed at
  // the end of the stop bit and drops it on an idle cycle with Ready low.
  always @(posedge i_Clk) begin : tx_model
    if (!tx_sending) begin
      tx_serial <= 1'b1;
      if (o_Tx_Ready === 1'b1) begin
        tx_sending <= 1'b1;
        tx_tick    <= 1;
        tx_serial  <= 1'b0;
      end else begin
        tx_completed <= 1'b0;
      end
    end else if (tx_tick == 10 * CLKS) begin
      tx_sending   <= 1'b0;
      tx_completed <= 1'b1;
      tx_serial    <= 1'b1;
    end else begin
      tx_tick <= tx_tick + 1;
      if (tx_tick / CLKS == 0)      tx_serial <= 1'b0;
      else if (tx_tick / CLKS == 9) tx_serial <= 1'b1;
      else                          tx_serial <= o_Tx_Byte[3'(tx_tick / CLKS - 1)];
    end
  end

  // Reference model: FIFO as a queue; the link is free, has a frame out, or is waiting
  // for the transmitter's done flag to clear.
  logic [7:0] mq[$];
  logic [7:0] line_exp[$];
  logic [7:0] m_byte = 8'h00;
  logic       m_ready = 1'b0, m_ovf = 1'b0;
  int         m_link = 0;
  int         m_pops = 0;
  int         n_ready = 0;
  int         ignore_cnt = 0;

  always @(posedge i_Clk) begin : ref_model
    logic pop, accept;
    if (i_Rst) begin
      ignore_cnt += line_exp.size();
      line_exp.delete();
      mq.delete();
      m_link  = 0;
      m_byte  = 8'h00;
      m_ready = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      pop     = (m_link == 0) && (mq.size() != 0);
      accept  = i_Wr_En && ((mq.size() < DEPTH) || pop);
      m_ovf   = i_Wr_En && !accept;
      m_ready = pop;
      if (pop) begin
        m_byte = mq.pop_front();
        line_exp.push_back(m_byte);
        m_pops++;
        m_link = 1;
      end else if (m_link == 1 && tx_completed) begin
        m_link = 2;
      end else if (m_link == 2 && !tx_completed) begin
        m_link = 0;
      end
      if (accept) mq.push_back(i_Wr_Byte);
    end
    #1;
    check("cyc_count", 32'(o_Count), mq.size());
    check("cyc_empty", 32'(o_Empty), 32'(mq.size() == 0));
    check("cyc_full", 32'(o_Full), 32'(mq.size() == DEPTH));
    check("cyc_overflow", 32'(o_Overflow), 32'(m_ovf));
    check("cyc_ready", 32'(o_Tx_Ready), 32'(m_ready));
    check("cyc_tx_byte", 32'(o_Tx_Byte), 32'(m_byte));
    if (o_Tx_Ready === 1'b1) n_ready++;
  end

  // Serial-line decoder sampling mid-bit.
  int n_frames = 0, n_ignored = 0;
  bit seen_14 = 1'b0;

  initial begin : line_mon
    logic [7:0] rx;
    logic       start_ok, stop_bit;
    forever begin
      @(posedge i_Clk); #1;
      if (tx_serial === 1'b0) begin
        repeat (CLKS / 2) @(posedge i_Clk);
        #1 start_ok = (tx_serial === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLKS) @(posedge i_Clk);
          #1 rx[i] = tx_serial;
        end
        repeat (CLKS) @(posedge i_Clk);
        #1 stop_bit = tx_serial;
        if (ignore_cnt > 0) begin
          ignore_cnt--;
          n_ignored++;
        end else begin
          n_frames++;
          if (rx == 8'h14) seen_14 = 1'b1;
          check("line_start_bit", 32'(start_ok), 1);
          check("line_stop_bit", 32'(stop_bit), 1);
          check("line_frame_expected", 32'(line_exp.size() != 0), 1);
          if (line_exp.size() != 0) check("line_byte", 32'(rx), 32'(line_exp.pop_front()));
        end
      end
    end
  end

  task automatic wait_idle(input string name, input int limit);
    bit done = 1'b0;
    for (int c = 0; c < limit && !done; c++) begin
      @(negedge i_Clk);
      done = (mq.size() == 0) && (line_exp.size() == 0) && !tx_sending && !tx_completed &&
             (m_link == 0);
    end
    check(name, 32'(done), 1);
  endtask

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_byte;
    int         count;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin : stimulus
    int  base_frames, base_ready;
    bit  ok;

    vecs = '{
      '{1'b1, 8'h10, 1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 8'h11, 2, 1'b0, 1'b0, 1'b0},
      '{1'b1, 8'h12, 3, 1'b0, 1'b0, 1'b0},
      '{1'b1, 8'h13, 4, 1'b1, 1'b0, 1'b0},
      '{1'b1, 8'h14, 4, 1'b1, 1'b0, 1'b1},
      '{1'b0, 8'h00, 4, 1'b1, 1'b0, 1'b0}
    };

    i_Rst = 1'b1; i_Wr_En = 1'b0; i_Wr_Byte = 8'h00;
    repeat (2) @(negedge i_Clk);
    check("rst_count", 32'(o_Count), 0);
    check("rst_empty", 32'(o_Empty), 1);
    check("rst_full", 32'(o_Full), 0);
    check("rst_overflow", 32'(o_Overflow), 0);
    check("rst_ready", 32'(o_Tx_Ready), 0);
    check("rst_tx_byte", 32'(o_Tx_Byte), 32'h00);
    i_Rst = 1'b0;
    @(negedge i_Clk);

    // Single byte: Ready exactly one cycle, two edges after the write.
    base_frames = n_frames;
    i_Wr_En = 1'b1; i_Wr_Byte = 8'hA5;
    @(negedge i_Clk);
    i_Wr_En = 1'b0;
    check("single_e0_count", 32'(o_Count), 1);
    check("single_e0_empty", 32'(o_Empty), 0);
    check("single_e0_ready", 32'(o_Tx_Ready), 0);
    @(negedge i_Clk);
    check("single_e1_ready", 32'(o_Tx_Ready), 1);
    check("single_e1_byte", 32'(o_Tx_Byte), 32'hA5);
    check("single_e1_empty", 32'(o_Empty), 1);
    @(negedge i_Clk);
    check("single_e2_ready", 32'(o_Tx_Ready), 0);
    check("single_e2_byte", 32'(o_Tx_Byte), 32'hA5);
    wait_idle("single_idle", 200);
    check("single_frames", n_frames - base_frames, 1);

    // Burst of three back-to-back writes.
    base_frames = n_frames; base_ready = n_ready;
    for (int b = 1; b <= 3; b++) begin
      i_Wr_En = 1'b1; i_Wr_Byte = 8'(b);
      @(negedge i_Clk);
    end
    i_Wr_En = 1'b0;
    wait_idle("burst_idle", 400);
    check("burst_frames", n_frames - base_frames, 3);
    check("burst_ready_pulses", n_ready - base_ready, 3);

    // Fill while a leader frame keeps the link busy, then overflow.
    base_frames = n_frames;
    i_Wr_En = 1'b1; i_Wr_Byte = 8'hEE;
    @(negedge i_Clk);
    i_Wr_En = 1'b0;
    @(negedge i_Clk);
    for (int r = 0; r < 6; r++) begin
      i_Wr_En = vecs[r].wr_en; i_Wr_Byte = vecs[r].wr_byte;
      @(negedge i_Clk);
      check($sformatf("fill%0d_count", r), 32'(o_Count), vecs[r].count);
      check($sformatf("fill%0d_full", r), 32'(o_Full), 32'(vecs[r].full));
      check($sformatf("fill%0d_empty", r), 32'(o_Empty), 32'(vecs[r].empty));
      check($sformatf("fill%0d_overflow", r), 32'(o_Overflow), 32'(vecs[r].ovf));
    end
    i_Wr_En = 1'b0;

    // Write on the very edge that pops from a full FIFO: three cycles after done.
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge i_Clk);
      ok = tx_completed;
    end
    check("full_done_seen", 32'(ok), 1);
    repeat (2) @(negedge i_Clk);
    check("full_gap_no_early_ready", 32'(o_Tx_Ready), 0);
    i_Wr_En = 1'b1; i_Wr_Byte = 8'h20;
    @(negedge i_Clk);
    i_Wr_En = 1'b0;
    check("simul_count", 32'(o_Count), 4);
    check("simul_full", 32'(o_Full), 1);
    check("simul_overflow", 32'(o_Overflow), 0);
    check("simul_ready", 32'(o_Tx_Ready), 1);
    check("simul_byte", 32'(o_Tx_Byte), 32'h10);
    wait_idle("full_idle", 1000);
    check("full_frames", n_frames - base_frames, 6);
    check("dropped_byte_not_sent", 32'(seen_14), 0);

    // Reset in mid-frame with three bytes queued.
    for (int b = 0; b < 4; b++) begin
      i_Wr_En = 1'b1; i_Wr_Byte = 8'(8'h30 + b);
      @(negedge i_Clk);
    end
    i_Wr_En = 1'b0;
    check("prerst_count", 32'(o_Count), 3);
    repeat (8) @(negedge i_Clk);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    check("midrst_count", 32'(o_Count), 0);
    check("midrst_empty", 32'(o_Empty), 1);
    check("midrst_full", 32'(o_Full), 0);
    check("midrst_ready", 32'(o_Tx_Ready), 0);
    check("midrst_byte", 32'(o_Tx_Byte), 32'h00);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge i_Clk);
      ok = !tx_sending && !tx_completed;
    end
    check("midrst_tx_settled", 32'(ok), 1);
    base_frames = n_frames;
    i_Wr_En = 1'b1; i_Wr_Byte = 8'h5A;
    @(negedge i_Clk);
    i_Wr_En = 1'b0;
    wait_idle("postrst_idle", 200);
    check("postrst_frames", n_frames - base_frames, 1);

    // Random traffic: dense (frequent overflow) then sparse.
    for (int c = 0; c < 300; c++) begin
      i_Wr_En = ($urandom_range(0, 2) == 0);
      i_Wr_Byte = 8'($urandom_range(0, 255));
      @(negedge i_Clk);
    end
    i_Wr_En = 1'b0;
    wait_idle("rand_dense_idle", 2000);
    for (int c = 0; c < 600; c++) begin
      i_Wr_En = ($urandom_range(0, 49) == 0);
      i_Wr_Byte = 8'($urandom_range(0, 255));
      @(negedge i_Clk);
    end
    i_Wr_En = 1'b0;
    wait_idle("rand_sparse_idle", 2000);
    check("frames_total", n_frames + n_ignored, m_pops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
